// File: rtl/rs_lock_arbiter_pkg.sv
// Shared definitions for the RS-latch lock arbiter: FSM state encoding,
// default parameter values and an index-width helper.
package rs_lock_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SET   = 3'd2,
      ST_HELD  = 3'd3,
      ST_CLR   = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam int DEF_N_REQ       = 4;
   localparam int DEF_TIMEOUT     = 255;
   localparam int DEF_CONFIRM_MAX = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs_lock_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, so the requester at ptr has the lowest priority.
module rr_picker
   import rs_lock_arbiter_pkg::*;
#(
   parameter int N = DEF_N_REQ,
   parameter int W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         cand = W'((int'(ptr) + i) % N);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rs_lock_arbiter.sv
// Round-robin owner of one external RS flip-flop used as a lock flag; every
// set/clear is confirmed through q_in, and S and R are never driven together.
module rs_lock_arbiter
   import rs_lock_arbiter_pkg::*;
#(
   parameter  int N_REQ       = DEF_N_REQ,
   parameter  int TIMEOUT     = DEF_TIMEOUT,
   parameter  int CONFIRM_MAX = DEF_CONFIRM_MAX,
   localparam int IW          = idx_w(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] rel,
   input  logic             q_in,
   output logic             s_out,
   output logic             r_out,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    owner_id,
   output logic             busy,
   output logic             timeout_evt,
   output logic             fault
);

   localparam int HW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(CONFIRM_MAX + 1);

   state_t           state, state_next;
   logic [IW-1:0]    ptr, ptr_next, owner_next, pick_idx;
   logic             pick_valid;
   logic [HW-1:0]    hold_cnt, hold_next;
   logic [CW-1:0]    conf_cnt, conf_next;
   logic             tevt_next;
   logic [N_REQ-1:0] grant_next;
   logic             conf_last, hold_last, owner_done;

   rr_picker #(.N(N_REQ), .W(IW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // conf_cnt counts unconfirmed cycles already spent in the current state
   assign conf_last  = (conf_cnt == CW'(CONFIRM_MAX - 1));
   assign hold_last  = (hold_cnt == HW'(TIMEOUT));
   assign owner_done = rel[owner_id] | ~req[owner_id];

   always_comb begin
      state_next = state;
      owner_next = owner_id;
      ptr_next   = ptr;
      tevt_next  = 1'b0;
      case (state)
         ST_INIT: begin
            if (!q_in)          state_next = ST_IDLE;
            else if (conf_last) state_next = ST_FAULT;
         end
         ST_IDLE: begin
            if (q_in) begin
               state_next = ST_FAULT;
            end else if (pick_valid) begin
               state_next = ST_SET;
               owner_next = pick_idx;
            end
         end
         ST_SET: begin
            if (q_in)           state_next = ST_HELD;
            else if (conf_last) state_next = ST_FAULT;
         end
         ST_HELD: begin
            // a simultaneous release wins over the timeout, so no pulse then
            if (!q_in) begin
               state_next = ST_FAULT;
            end else if (owner_done) begin
               state_next = ST_CLR;
            end else if (hold_last) begin
               state_next = ST_CLR;
               tevt_next  = 1'b1;
            end
         end
         ST_CLR: begin
            if (!q_in) begin
               state_next = ST_IDLE;
               ptr_next   = owner_id;
            end else if (conf_last) begin
               state_next = ST_FAULT;
            end
         end
         ST_FAULT: state_next = ST_FAULT;
         default:  state_next = ST_FAULT;
      endcase

      conf_next = '0;
      hold_next = HW'(1);
      if (state_next == state) begin
         conf_next = (conf_cnt == CW'(CONFIRM_MAX)) ? conf_cnt : conf_cnt + CW'(1);
         hold_next = hold_last ? hold_cnt : hold_cnt + HW'(1);
      end

      grant_next = '0;
      if (state_next == ST_HELD) grant_next[owner_next] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_INIT;
         ptr         <= IW'(N_REQ - 1);
         owner_id    <= '0;
         hold_cnt    <= '0;
         conf_cnt    <= '0;
         s_out       <= 1'b0;
         r_out       <= 1'b0;
         grant       <= '0;
         busy        <= 1'b0;
         timeout_evt <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         owner_id    <= owner_next;
         hold_cnt    <= hold_next;
         conf_cnt    <= conf_next;
         s_out       <= (state_next == ST_SET);
         r_out       <= (state_next == ST_INIT) || (state_next == ST_CLR);
         grant       <= grant_next;
         busy        <= (state_next != ST_IDLE);
         timeout_evt <= tevt_next;
         fault       <= (state_next == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_rs_lock_arbiter.sv
// Bench for rs_lock_arbiter: an RS latch model closes the q_in loop, a
// phase-level reference model predicts every output cycle by cycle.
module tb_rs_lock_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam int CM = 4;
   localparam int IW = $clog2(N);

   localparam int M_CLEAR0   = 0;
   localparam int M_FREE     = 1;
   localparam int M_SETTING  = 2;
   localparam int M_OWNED    = 3;
   localparam int M_CLEARING = 4;
   localparam int M_DEAD     = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  rel = '0;
   logic          q_in;
   logic          s_out, r_out, busy, timeout_evt, fault;
   logic [N-1:0]  grant;
   logic [IW-1:0] owner_id;

   logic q_state = 1'b1;
   logic force_q = 1'b0;
   logic force_val = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] exp_q[$];
   logic [N-1:0] obs_q[$];

   int held, evt, cnt;
   bit saw_r;

   rs_lock_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CONFIRM_MAX(CM)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .rel         (rel),
      .q_in        (q_in),
      .s_out       (s_out),
      .r_out       (r_out),
      .grant       (grant),
      .owner_id    (owner_id),
      .busy        (busy),
      .timeout_evt (timeout_evt),
      .fault       (fault)
   );

   // ---------------- clock / latch ----------------
   always #5 clk = ~clk;

   always @(s_out or r_out) begin
      if (s_out)      q_state = 1'b1;
      else if (r_out) q_state = 1'b0;
   end

   assign q_in = force_q ? force_val : q_state;

   // ---------------- reference model ----------------
   int            m_mode = M_CLEAR0;
   int            m_wait = 0;
   int            m_last = N - 1;
   logic [IW-1:0] m_owner = '0;
   logic          e_s = 1'b0, e_r = 1'b0, e_busy = 1'b0, e_tevt = 1'b0, e_fault = 1'b0;
   logic [N-1:0]  e_grant = '0;

   task automatic model_step();
      int            nxt;
      bit            ev, found;
      logic [IW-1:0] c;
      nxt = m_mode;
      ev = 1'b0;
      found = 1'b0;
      case (m_mode)
         M_CLEAR0, M_CLEARING: begin
            if (!q_in) begin
               if (m_mode == M_CLEARING) m_last = int'(m_owner);
               nxt = M_FREE;
            end else if (m_wait + 1 >= CM) nxt = M_DEAD;
         end
         M_FREE: begin
            if (q_in) nxt = M_DEAD;
            else begin
               for (int k = 1; k <= N; k++) begin
                  c = IW'((m_last + k) % N);
                  if (!found && req[c]) begin
                     found = 1'b1;
                     m_owner = c;
                     nxt = M_SETTING;
                  end
               end
            end
         end
         M_SETTING: begin
            if (q_in) nxt = M_OWNED;
            else if (m_wait + 1 >= CM) nxt = M_DEAD;
         end
         M_OWNED: begin
            if (!q_in) nxt = M_DEAD;
            else if (rel[m_owner] || !req[m_owner]) nxt = M_CLEARING;
            else if (m_wait + 1 >= TO) begin
               nxt = M_CLEARING;
               ev = 1'b1;
            end
         end
         default: nxt = M_DEAD;
      endcase
      m_wait  = (nxt == m_mode) ? m_wait + 1 : 0;
      m_mode  = nxt;
      e_s     = (m_mode == M_SETTING);
      e_r     = (m_mode == M_CLEAR0) || (m_mode == M_CLEARING);
      e_grant = (m_mode == M_OWNED) ? (N'(1) << m_owner) : '0;
      e_busy  = (m_mode != M_FREE);
      e_fault = (m_mode == M_DEAD);
      e_tevt  = ev;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_CLEAR0; m_wait = 0; m_last = N - 1; m_owner = '0;
         e_s = 1'b0; e_r = 1'b0; e_grant = '0; e_busy = 1'b0; e_tevt = 1'b0; e_fault = 1'b0;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (s_out !== e_s || r_out !== e_r || grant !== e_grant || owner_id !== m_owner ||
             busy !== e_busy || timeout_evt !== e_tevt || fault !== e_fault) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t dut s=%b r=%b g=%b own=%0d busy=%b tevt=%b flt=%b model s=%b r=%b g=%b own=%0d busy=%b tevt=%b flt=%b",
                     $time, s_out, r_out, grant, owner_id, busy, timeout_evt, fault,
                     e_s, e_r, e_grant, m_owner, e_busy, e_tevt, e_fault);
         end
         checks++;
         if (s_out & r_out) begin
            errors++;
            $display("FAIL sr_overlap t=%0t s=%b r=%b want not both 1", $time, s_out, r_out);
         end
         checks++;
         if ($countones(grant) > 1) begin
            errors++;
            $display("FAIL grant_onehot t=%0t grant=%b want at most one bit", $time, grant);
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req = '0;
      rel = '0;
      force_q = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_grant(input string name, input int budget);
      for (int i = 0; i < budget && grant == '0; i++) @(negedge clk);
      checks++;
      if (grant == '0) begin
         errors++;
         $display("FAIL %s got=no_grant want=grant within %0d cycles", name, budget);
      end
   endtask

   task automatic collect_grants(input int n, input int rel_after, input int budget);
      int h;
      h = 0;
      obs_q.delete();
      for (int cyc = 0; cyc < budget && obs_q.size() < n; cyc++) begin
         @(negedge clk);
         rel = '0;
         if (grant != '0) begin
            if (h == 0) obs_q.push_back(grant);
            h++;
            if (rel_after != 0 && h == rel_after) rel = grant;
         end else begin
            h = 0;
         end
      end
      rel = '0;
   endtask

   task automatic check_seq(input string name);
      logic [N-1:0] e, g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=missing want=%b", name, e);
         end else begin
            g = obs_q.pop_front();
            chk(name, 32'(g), 32'(e));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [IW-1:0] b;

      // reset with the latch stuck set: INIT must drive R until Q falls
      force_q = 1'b1;
      force_val = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_r_out", 32'(r_out), 0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("init_r_out", 32'(r_out), 1);
      chk("init_busy", 32'(busy), 1);
      force_q = 1'b0;
      @(negedge clk);
      chk("init_done_busy", 32'(busy), 0);
      chk("init_done_r", 32'(r_out), 0);
      chk("init_done_s", 32'(s_out), 0);

      // single request: s_out at t+1, grant at t+2, release by pulse
      req = 4'b0001;
      @(negedge clk);
      chk("lat_s_out", 32'(s_out), 1);
      chk("lat_no_grant", 32'(grant), 0);
      @(negedge clk);
      chk("lat_grant", 32'(grant), 32'h1);
      chk("lat_s_drop", 32'(s_out), 0);
      rel = 4'b0001;
      @(negedge clk);
      rel = '0;
      req = '0;
      chk("rel_r_out", 32'(r_out), 1);
      chk("rel_grant", 32'(grant), 0);
      @(negedge clk);
      chk("rel_idle", 32'(busy), 0);

      // all requesting, each owner releases after 3 cycles
      do_reset();
      req = 4'b1111;
      collect_grants(5, 3, 200);
      req = '0;
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      check_seq("rr_seq");

      // hold timeout on requester 2, then others served before it again
      do_reset();
      req = 4'b0100;
      wait_grant("to_first_grant", 20);
      req = 4'b1111;
      held = 0;
      evt = 0;
      for (int i = 0; i < 11; i++) begin
         if (grant == 4'b0100) held++;
         if (timeout_evt) evt++;
         @(negedge clk);
      end
      chk("to_hold_cycles", held, TO);
      chk("to_evt_pulses", evt, 1);
      collect_grants(4, 0, 200);
      req = '0;
      exp_q = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
      check_seq("to_regrant_seq");

      // latch stuck low during SET
      do_reset();
      force_q = 1'b1;
      force_val = 1'b0;
      req = 4'b0001;
      cnt = 0;
      for (int i = 0; i < 30 && !fault; i++) begin
         @(negedge clk);
         if (s_out) cnt++;
      end
      chk("stuck_s_cycles", cnt, CM);
      chk("stuck_fault", 32'(fault), 1);
      chk("stuck_busy", 32'(busy), 1);
      chk("stuck_grant", 32'(grant), 0);
      chk("stuck_sr", 32'({s_out, r_out}), 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req = N'($urandom_range(0, 15));
      end
      chk("stuck_sticky", 32'(fault), 1);

      // asynchronous reset while HELD
      do_reset();
      req = 4'b0100;
      wait_grant("ar_grant", 20);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_grant_drop", 32'(grant), 0);
      chk("ar_busy", 32'(busy), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      req = 4'b1111;
      saw_r = 1'b0;
      for (int i = 0; i < 30 && grant == '0; i++) begin
         @(negedge clk);
         if (r_out) saw_r = 1'b1;
      end
      chk("ar_reclear", 32'(saw_r), 1);
      chk("ar_first_grant", 32'(grant), 32'h1);

      // randomized traffic with occasional latch glitches and resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rel = '0;
         force_q = 1'b0;
         if (e_fault) begin
            do_reset();
            continue;
         end
         if ($urandom_range(0, 3) == 0) begin
            b = IW'($urandom_range(0, N - 1));
            req[b] = ~req[b];
         end
         if ($urandom_range(0, 7) == 0) rel = N'(1) << IW'($urandom_range(0, N - 1));
         if ($urandom_range(0, 299) == 0) begin
            force_q = 1'b1;
            force_val = ~q_state;
         end
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog got=still_running want=finished t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
